// File: rtl/mips_tb_pkg.sv
// Shared types and defaults for the MIPS run monitor and the benches that use it.
package mips_tb_pkg;

    typedef enum logic [1:0] {
        MON_RUN     = 2'd0,
        MON_PASS    = 2'd1,
        MON_FAIL    = 2'd2,
        MON_TIMEOUT = 2'd3
    } mon_state_t;

    localparam int MON_DEFAULT_MAX_CYCLES = 25;

endpackage

// File: rtl/mon_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones instead of wrapping.
module mon_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mips_run_monitor.sv
// Watches the core's data-memory write stream, matches it in order against an expected
// table and latches a sticky PASS / FAIL / TIMEOUT verdict. Purely an observer.
module mips_run_monitor
    import mips_tb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_EXP    = 4,
    parameter int MAX_CYCLES = MON_DEFAULT_MAX_CYCLES,
    parameter int CNT_W      = 16,
    parameter bit STRICT     = 1'b1,
    localparam int MW        = $clog2(NUM_EXP + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            memwrite,
    input  logic [WIDTH-1:0]                dataadr,
    input  logic [WIDTH-1:0]                writedata,
    input  logic [NUM_EXP-1:0][WIDTH-1:0]   exp_adr,
    input  logic [NUM_EXP-1:0][WIDTH-1:0]   exp_data,
    input  logic [MW-1:0]                   num_exp,
    output logic                            done,
    output logic                            pass,
    output logic                            fail,
    output logic                            timeout,
    output logic [CNT_W-1:0]                cycle_count,
    output logic [MW-1:0]                   match_count,
    output logic [WIDTH-1:0]                fail_adr,
    output logic [WIDTH-1:0]                fail_data
);

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    mon_state_t       state_q, state_d;
    logic [MW-1:0]    match_count_q, match_count_d;
    logic [WIDTH-1:0] fail_adr_q, fail_adr_d;
    logic [WIDTH-1:0] fail_data_q, fail_data_d;
    logic [MW-1:0]    match_inc;
    logic [NUM_EXP-1:0] exp_hit;
    logic             wr_match;
    logic             wr_valid;
    logic             write_verdict;

    mon_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk     (clk),
        .clear_i (reset),
        .en_i    (state_q == MON_RUN),
        .count_o (cycle_count)
    );

    // One comparator per table entry; only the entry at the current match pointer may hit.
    for (genvar gi = 0; gi < NUM_EXP; gi++) begin : g_cmp
        assign exp_hit[gi] = (match_count_q == MW'(gi))
                           && (dataadr   == exp_adr[gi])
                           && (writedata == exp_data[gi]);
    end

    assign wr_match  = |exp_hit;
    assign wr_valid  = (memwrite == 1'b1);
    assign match_inc = match_count_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        match_count_d = match_count_q;
        fail_adr_d    = fail_adr_q;
        fail_data_d   = fail_data_q;
        write_verdict = 1'b0;
        if (state_q == MON_RUN) begin
            if (wr_valid) begin
                if (num_exp == '0) begin
                    if (STRICT) begin
                        state_d       = MON_FAIL;
                        fail_adr_d    = dataadr;
                        fail_data_d   = writedata;
                        write_verdict = 1'b1;
                    end
                end else if (match_count_q < num_exp) begin
                    if (wr_match) begin
                        match_count_d = match_inc;
                        if (match_inc == num_exp) begin
                            state_d       = MON_PASS;
                            write_verdict = 1'b1;
                        end
                    end else if (STRICT) begin
                        state_d       = MON_FAIL;
                        fail_adr_d    = dataadr;
                        fail_data_d   = writedata;
                        write_verdict = 1'b1;
                    end
                end
            end
            // A write decided on the last cycle takes precedence over the timeout.
            if (!write_verdict && (cycle_count == LAST_CYCLE)) begin
                state_d = (num_exp == '0) ? MON_PASS : MON_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MON_RUN;
            match_count_q <= '0;
            fail_adr_q    <= '0;
            fail_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            match_count_q <= match_count_d;
            fail_adr_q    <= fail_adr_d;
            fail_data_q   <= fail_data_d;
        end
    end

    assign pass        = (state_q == MON_PASS);
    assign fail        = (state_q == MON_FAIL);
    assign timeout     = (state_q == MON_TIMEOUT);
    assign done        = pass | fail | timeout;
    assign match_count = match_count_q;
    assign fail_adr    = fail_adr_q;
    assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor: directed table, reset-abort sequence and random runs on a strict and a lenient instance.
module tb_mips_run_monitor;

    localparam int MAXC  = 25;
    localparam int RUN_C = 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic [3:0][31:0] exp_adr_r = '0;
    logic [3:0][31:0] exp_data_r = '0;
    logic [2:0] num_exp_r = '0;

    logic done_s, pass_s, fail_s, timeout_s;
    logic [15:0] cc_s;
    logic [2:0] mc_s;
    logic [31:0] fa_s, fd_s;
    logic done_l, pass_l, fail_l, timeout_l;
    logic [15:0] cc_l;
    logic [2:0] mc_l;
    logic [31:0] fa_l, fd_l;

    int n_checks = 0;
    int n_fail = 0;

    bit          sv[64];
    logic [31:0] sa[64];
    logic [31:0] sd[64];

    always #5 clk = ~clk;

    mips_run_monitor #(.WIDTH(32), .NUM_EXP(4), .MAX_CYCLES(MAXC), .CNT_W(16), .STRICT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_adr(exp_adr_r), .exp_data(exp_data_r), .num_exp(num_exp_r),
        .done(done_s), .pass(pass_s), .fail(fail_s), .timeout(timeout_s),
        .cycle_count(cc_s), .match_count(mc_s), .fail_adr(fa_s), .fail_data(fd_s));

    mips_run_monitor #(.WIDTH(32), .NUM_EXP(4), .MAX_CYCLES(MAXC), .CNT_W(16), .STRICT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_adr(exp_adr_r), .exp_data(exp_data_r), .num_exp(num_exp_r),
        .done(done_l), .pass(pass_l), .fail(fail_l), .timeout(timeout_l),
        .cycle_count(cc_l), .match_count(mc_l), .fail_adr(fa_l), .fail_data(fd_l));

    typedef struct packed {
        logic             strict;
        logic [2:0]       n;
        logic [3:0][31:0] ea;
        logic [3:0][31:0] ed;
        logic [2:0]       nw;
        logic [3:0][7:0]  wc;
        logic [3:0][31:0] wa;
        logic [3:0][31:0] wd;
        logic             ep, ef, et;
        logic [15:0]      ecc;
        logic [2:0]       emc;
        logic [31:0]      efa, efd;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) begin
            sv[i] = 1'b0;
            sa[i] = '0;
            sd[i] = '0;
        end
    endtask

    // Reset the monitors, then present sched[c] while cycle_count reads c.
    task automatic run_sched();
        reset = 1'b1;
        memwrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < RUN_C; c++) begin
            memwrite  = sv[c];
            dataadr   = sa[c];
            writedata = sd[c];
            @(negedge clk);
        end
        memwrite = 1'b0;
    endtask

    // Reference: walk the schedule cycle by cycle, stop at the first verdict.
    task automatic ref_run(input bit strict, output bit p, output bit f, output bit t,
                           output int cc, output int mc, output logic [31:0] fa, output logic [31:0] fd);
        bit decided;
        p = 0; f = 0; t = 0; cc = MAXC; mc = 0; fa = 0; fd = 0; decided = 0;
        for (int c = 0; c < MAXC && !decided; c++) begin
            if (sv[c]) begin
                if (num_exp_r == 0) begin
                    if (strict) begin f = 1; fa = sa[c]; fd = sd[c]; cc = c + 1; decided = 1; end
                end else if (sa[c] == exp_adr_r[mc] && sd[c] == exp_data_r[mc]) begin
                    mc++;
                    if (mc == int'(num_exp_r)) begin p = 1; cc = c + 1; decided = 1; end
                end else if (strict) begin
                    f = 1; fa = sa[c]; fd = sd[c]; cc = c + 1; decided = 1;
                end
            end
            if (!decided && c == MAXC - 1) begin
                if (num_exp_r == 0) p = 1; else t = 1;
                decided = 1;
            end
        end
    endtask

    task automatic check_dut(input bit strict, input string tag, input bit p, input bit f, input bit t,
                             input int cc, input int mc, input logic [31:0] fa, input logic [31:0] fd);
        check({tag, ".done"},    strict ? done_s    : done_l,    p | f | t);
        check({tag, ".pass"},    strict ? pass_s    : pass_l,    p);
        check({tag, ".fail"},    strict ? fail_s    : fail_l,    f);
        check({tag, ".timeout"}, strict ? timeout_s : timeout_l, t);
        check({tag, ".cycle_count"}, strict ? cc_s : cc_l, cc);
        check({tag, ".match_count"}, strict ? mc_s : mc_l, mc);
        check({tag, ".fail_adr"},  strict ? fa_s : fa_l, fa);
        check({tag, ".fail_data"}, strict ? fd_s : fd_l, fd);
    endtask

    task automatic load_vec(input vec_t v);
        num_exp_r  = v.n;
        exp_adr_r  = v.ea;
        exp_data_r = v.ed;
        clear_sched();
        for (int w = 0; w < int'(v.nw); w++) begin
            sv[v.wc[w]] = 1'b1;
            sa[v.wc[w]] = v.wa[w];
            sd[v.wc[w]] = v.wd[w];
        end
    endtask

    initial begin
        bit p, f, t;
        int cc, mc;
        logic [31:0] fa, fd;
        int ptr;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_dut(1'b1, "reset_s", 0, 0, 0, 0, 0, 0, 0);
        check_dut(1'b0, "reset_l", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) tbl[i] = '0;
        // single expected write matched while cycle_count reads 9
        tbl[0].strict = 1; tbl[0].n = 1; tbl[0].ea[0] = 84; tbl[0].ed[0] = 7;
        tbl[0].nw = 1; tbl[0].wc[0] = 9; tbl[0].wa[0] = 84; tbl[0].wd[0] = 7;
        tbl[0].ep = 1; tbl[0].ecc = 10; tbl[0].emc = 1;
        // wrong address fails; later correct write ignored
        tbl[1].strict = 1; tbl[1].n = 1; tbl[1].ea[0] = 84; tbl[1].ed[0] = 7;
        tbl[1].nw = 2; tbl[1].wc[0] = 5; tbl[1].wa[0] = 80; tbl[1].wd[0] = 7;
        tbl[1].wc[1] = 8; tbl[1].wa[1] = 84; tbl[1].wd[1] = 7;
        tbl[1].ef = 1; tbl[1].ecc = 6; tbl[1].efa = 80; tbl[1].efd = 7;
        // only one of two expected writes -> timeout
        tbl[2].strict = 1; tbl[2].n = 2; tbl[2].ea[0] = 84; tbl[2].ed[0] = 7;
        tbl[2].ea[1] = 88; tbl[2].ed[1] = 9;
        tbl[2].nw = 1; tbl[2].wc[0] = 3; tbl[2].wa[0] = 84; tbl[2].wd[0] = 7;
        tbl[2].et = 1; tbl[2].ecc = 25; tbl[2].emc = 1;
        // lenient: stray writes ignored
        tbl[3].strict = 0; tbl[3].n = 2; tbl[3].ea[0] = 4; tbl[3].ed[0] = 1;
        tbl[3].ea[1] = 8; tbl[3].ed[1] = 2; tbl[3].nw = 4;
        tbl[3].wc[0] = 2; tbl[3].wa[0] = 0;  tbl[3].wd[0] = 9;
        tbl[3].wc[1] = 4; tbl[3].wa[1] = 4;  tbl[3].wd[1] = 1;
        tbl[3].wc[2] = 6; tbl[3].wa[2] = 12; tbl[3].wd[2] = 3;
        tbl[3].wc[3] = 8; tbl[3].wa[3] = 8;  tbl[3].wd[3] = 2;
        tbl[3].ep = 1; tbl[3].ecc = 9; tbl[3].emc = 2;
        // same stream, strict: first stray write fails
        tbl[4] = tbl[3]; tbl[4].strict = 1; tbl[4].ep = 0; tbl[4].ef = 1;
        tbl[4].ecc = 3; tbl[4].emc = 0; tbl[4].efa = 0; tbl[4].efd = 9;
        // final match on the timeout edge wins
        tbl[5].strict = 1; tbl[5].n = 1; tbl[5].ea[0] = 84; tbl[5].ed[0] = 7;
        tbl[5].nw = 1; tbl[5].wc[0] = 24; tbl[5].wa[0] = 84; tbl[5].wd[0] = 7;
        tbl[5].ep = 1; tbl[5].ecc = 25; tbl[5].emc = 1;
        // empty table: strict write fails, lenient passes at timeout
        tbl[6].strict = 1; tbl[6].n = 0; tbl[6].nw = 1;
        tbl[6].wc[0] = 7; tbl[6].wa[0] = 1; tbl[6].wd[0] = 2;
        tbl[6].ef = 1; tbl[6].ecc = 8; tbl[6].efa = 1; tbl[6].efd = 2;
        tbl[7] = tbl[6]; tbl[7].strict = 0; tbl[7].ef = 0; tbl[7].ep = 1;
        tbl[7].ecc = 25; tbl[7].efa = 0; tbl[7].efd = 0;

        for (int i = 0; i < 8; i++) begin
            load_vec(tbl[i]);
            run_sched();
            check_dut(tbl[i].strict, $sformatf("vec%0d", i), tbl[i].ep, tbl[i].ef, tbl[i].et,
                      int'(tbl[i].ecc), int'(tbl[i].emc), tbl[i].efa, tbl[i].efd);
        end

        // Reset for one cycle while in FAIL, then an empty run passes at 25
        load_vec(tbl[1]);
        run_sched();
        check("abort.pre_fail", fail_s, 1);
        reset = 1'b1;
        num_exp_r = '0;
        @(negedge clk);
        reset = 1'b0;
        check_dut(1'b1, "abort.cleared", 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < RUN_C; c++) @(negedge clk);
        check_dut(1'b1, "abort.rerun", 1, 0, 0, 25, 0, 0, 0);

        // Random runs against the reference on both instances
        for (int r = 0; r < 40; r++) begin
            num_exp_r = 3'($urandom_range(0, 4));
            for (int i = 0; i < 4; i++) begin
                exp_adr_r[i]  = $urandom_range(0, 3) * 4;
                exp_data_r[i] = $urandom_range(0, 1);
            end
            clear_sched();
            ptr = 0;
            for (int c = 0; c < RUN_C; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    sv[c] = 1'b1;
                    if (num_exp_r != 0 && $urandom_range(0, 2) != 0) begin
                        sa[c] = exp_adr_r[ptr];
                        sd[c] = exp_data_r[ptr];
                        ptr = (ptr + 1) % int'(num_exp_r);
                    end else begin
                        sa[c] = $urandom_range(0, 3) * 4;
                        sd[c] = $urandom_range(0, 1);
                    end
                end
            end
            run_sched();
            ref_run(1'b1, p, f, t, cc, mc, fa, fd);
            check_dut(1'b1, $sformatf("rnd%0d_s", r), p, f, t, cc, mc, fa, fd);
            ref_run(1'b0, p, f, t, cc, mc, fa, fd);
            check_dut(1'b0, $sformatf("rnd%0d_l", r), p, f, t, cc, mc, fa, fd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
